// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM stage: access FSM state encoding
// and default datapath / timeout sizing.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam int DEFAULT_DATA_W         = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;
  localparam int DEFAULT_CNT_W          = 5;

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer: ready/valid request, wait-state stall,
// timeout abort and the sticky bus_err flag.
module dmem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic access,
  input  logic misaligned,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic mem_stall,
  output logic abort,
  output logic bus_err
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             at_limit;

  assign at_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign bus_err  = err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else if (!dmem_ready) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (at_limit) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Everything visible upstream is forced quiet while reset is held low.
  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    abort     = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              abort = 1'b1;
            end else begin
              dmem_req  = 1'b1;
              mem_stall = !dmem_ready;
            end
          end
        end
        WAIT: begin
          dmem_req = access & !misaligned;
          if (!dmem_ready) begin
            if (at_limit) abort = 1'b1;
            else          mem_stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB pipeline register: branch/jump redirect, data-memory
// access and writeback registers. Optional build macro: MISALIGN_CHECK_EN.
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              Branch_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              Jump_in,
  input  logic [DATA_W-1:0] jump_addr_in,
  input  logic [DATA_W-1:0] branch_addr_in,
  input  logic              ALU_zero_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] reg_read_data_2_in,
  input  logic [4:0]        EX_MEM_RegisterRd_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_stall,
  output logic              PCSrc,
  output logic [DATA_W-1:0] pc_target,
  output logic              EX_Flush,
  output logic              bus_err,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [DATA_W-1:0] mem_read_data_out,
  output logic [DATA_W-1:0] ALU_result_out,
  output logic [4:0]        MEM_WB_RegisterRd_out
);

  logic access;
  logic is_read;
  logic misaligned;
  logic abort;
  logic take;

  assign access     = MemRead_in | MemWrite_in;
  assign is_read    = MemRead_in & !MemWrite_in;
  assign dmem_addr  = ALU_result_in;
  assign dmem_wdata = reg_read_data_2_in;
  assign dmem_we    = MemWrite_in;

`ifdef MISALIGN_CHECK_EN
  assign misaligned = |ALU_result_in[1:0];
`else
  assign misaligned = 1'b0;
`endif

  dmem_access_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .access    (access),
    .misaligned(misaligned),
    .dmem_ready(dmem_ready),
    .dmem_req  (dmem_req),
    .mem_stall (mem_stall),
    .abort     (abort),
    .bus_err   (bus_err)
  );

  // Redirect: jump wins over a taken branch; held off while the stage stalls.
  assign take      = Jump_in | (Branch_in & ALU_zero_in);
  assign PCSrc     = reset & !mem_stall & take;
  assign pc_target = Jump_in ? jump_addr_in : branch_addr_in;
  assign EX_Flush  = PCSrc;

  // MEM/WB register: bubble on stall, squashed writeback on abort.
  always_ff @(posedge clk) begin
    if (!reset) begin
      RegWrite_out          <= 1'b0;
      MemtoReg_out          <= 1'b0;
      mem_read_data_out     <= '0;
      ALU_result_out        <= '0;
      MEM_WB_RegisterRd_out <= '0;
    end else if (mem_stall) begin
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
    end else begin
      RegWrite_out          <= RegWrite_in & !abort;
      MemtoReg_out          <= MemtoReg_in;
      mem_read_data_out     <= (is_read && !abort) ? dmem_rdata : '0;
      ALU_result_out        <= ALU_result_in;
      MEM_WB_RegisterRd_out <= EX_MEM_RegisterRd_in;
    end
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register; consumes the EX/MEM register outputs.
- Resolves branch and jump, and drives the PC redirect and the flush requests.
- Performs data-memory access over a ready/valid handshake, with wait-state stalling and a timeout.
- Registers the results toward writeback.

Parameters:
DATA_W, 32, datapath and address width
TIMEOUT_CYCLES, 16, maximum WAIT cycles before an access is aborted (must be >=2)
CNT_W, 5, width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT_CYCLES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
RegWrite_in  in  1  WB control from EX/MEM
MemtoReg_in  in  1  WB control from EX/MEM
Branch_in  in  1  MEM control from EX/MEM
MemRead_in  in  1  MEM control from EX/MEM
MemWrite_in  in  1  MEM control from EX/MEM
Jump_in  in  1  MEM control from EX/MEM
jump_addr_in  in  DATA_W  jump target
branch_addr_in  in  DATA_W  branch target
ALU_zero_in  in  1  branch condition
ALU_result_in  in  DATA_W  memory address / ALU value
reg_read_data_2_in  in  DATA_W  store data
EX_MEM_RegisterRd_in  in  5  destination register
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = write
dmem_addr  out  DATA_W  memory address
dmem_wdata  out  DATA_W  write data
dmem_ready  in  1  memory accepts/completes the current request
dmem_rdata  in  DATA_W  read data, valid when dmem_ready=1
mem_stall  out  1  hold enable for PC, IF/ID, ID/EX, EX/MEM
PCSrc  out  1  PC redirect valid
pc_target  out  DATA_W  redirect address
EX_Flush  out  1  flush request to upstream registers
bus_err  out  1  sticky timeout flag
RegWrite_out  out  1  MEM/WB register
MemtoReg_out  out  1  MEM/WB register
mem_read_data_out  out  DATA_W  MEM/WB register
ALU_result_out  out  DATA_W  MEM/WB register
MEM_WB_RegisterRd_out  out  5  MEM/WB register

Behaviour:
- Reset:
  - reset=0 sampled at a posedge: FSM goes to IDLE, counter=0, bus_err=0, all MEM/WB outputs=0.
  - While reset=0, dmem_req, mem_stall, PCSrc and EX_Flush are forced to 0 combinationally.
  - Reset mid-WAIT abandons the access; no writeback occurs.
- access = MemRead_in | MemWrite_in. If both are 1, the access is a write.
- Memory port is combinational from the inputs:
  - dmem_addr = ALU_result_in
  - dmem_wdata = reg_read_data_2_in
  - dmem_we = MemWrite_in
  - dmem_req = access in IDLE or WAIT
- FSM states: IDLE, WAIT.
  - IDLE, access=0: no stall; MEM/WB loads the inputs every cycle.
  - IDLE, access=1, dmem_ready=1: zero-wait completion. Capture dmem_rdata, load MEM/WB, no stall.
  - IDLE, access=1, dmem_ready=0: mem_stall=1, go to WAIT, counter=1.
  - WAIT, dmem_ready=0: mem_stall=1, counter increments.
  - WAIT, dmem_ready=1: mem_stall=0, load MEM/WB with dmem_rdata, return to IDLE.
  - WAIT with counter==TIMEOUT_CYCLES and dmem_ready=0 (timeout):
    - Abort: mem_stall=0, go to IDLE, set bus_err=1.
    - Load MEM/WB with mem_read_data_out=0 and RegWrite_out=0.
- Stall cycles: MEM/WB loads a bubble (RegWrite_out=0, MemtoReg_out=0; data fields hold their previous values). Inputs are held upstream by mem_stall.
- Write accesses complete identically; mem_read_data_out then loads 0.
- Redirect (combinational, suppressed while mem_stall=1):
  - Jump_in=1: PCSrc=1, pc_target=jump_addr_in. Jump has priority.
  - Else Branch_in & ALU_zero_in: PCSrc=1, pc_target=branch_addr_in.
  - Otherwise PCSrc=0, pc_target=branch_addr_in.
  - EX_Flush = PCSrc.
- MEM/WB latency is 1 cycle after completion. RegisterRd and ALU_result pass through unchanged.
- bus_err is cleared only by reset.

Optional Feature:
MISALIGN_CHECK_EN
- Defined: an access with dmem_addr[1:0]!=0 is not issued (dmem_req=0). It completes in the same cycle as a timeout does: bus_err=1, RegWrite_out=0, mem_read_data_out=0, no stall.
- Undefined: addresses are passed unchecked.

Decomposition:
- Package mem_stage_pkg: FSM state enum (IDLE=0, WAIT=1), default TIMEOUT_CYCLES, DATA_W.
- One sub-module, dmem_access_fsm, contains the FSM, the timeout counter, the stall generation and bus_err.
- The parent module holds the redirect logic and the MEM/WB register.

Test Plan:
- Reset: reset=0 for 2 cycles during WAIT -> all outputs 0, dmem_req=0, FSM IDLE after release.
- Load to addr 0x10, dmem_ready high in the same cycle, rdata 0xDEADBEEF, Rd=5 -> no stall. Next cycle mem_read_data_out=0xDEADBEEF, RegWrite_out=1, MEM_WB_RegisterRd_out=5.
- Load with dmem_ready asserted after 3 cycles -> mem_stall=1 for exactly 3 cycles with bubbles (RegWrite_out=0). Data is captured on the 4th cycle.
- Store with dmem_ready held low -> mem_stall=1 for TIMEOUT_CYCLES cycles, then bus_err=1 (sticky), RegWrite_out=0.
- Branch_in=1, ALU_zero_in=1, branch_addr=0x40 -> PCSrc=1, pc_target=0x40, EX_Flush=1. With Jump_in=1 as well, jump_addr=0x80 -> pc_target=0x80.
- With MISALIGN_CHECK_EN defined, load at addr 0x13 -> dmem_req=0, bus_err=1, no stall.
